// File: rtl/sweep_pair_tracker_pkg.sv
// Shared definitions for the sweep pair tracker: default widths, FSM encoding
// and the bit layout of an incoming sweep record.
package sweep_pair_tracker_pkg;

    localparam int NUM_SENSORS_DEF = 3;
    localparam int TS_WIDTH_DEF    = 17;
    localparam int ID_WIDTH_DEF    = 17;

    // Record layout: {ts[N-1], ..., ts[0], id}, id at the LSBs.
    localparam int ID_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_STORE  = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    function automatic int ts_lsb(input int id_width, input int ts_width, input int sensor);
        return ID_LSB + id_width + sensor * ts_width;
    endfunction

endpackage

// File: rtl/sweep_pair_tracker_if.sv
// Record-in / pair-out handshake bundle for the sweep pair tracker.
// The slave modport is the tracker's view; master is the producer/consumer side.
interface sweep_pair_tracker_if #(
    parameter int NUM_SENSORS = sweep_pair_tracker_pkg::NUM_SENSORS_DEF,
    parameter int TS_WIDTH    = sweep_pair_tracker_pkg::TS_WIDTH_DEF,
    parameter int ID_WIDTH    = sweep_pair_tracker_pkg::ID_WIDTH_DEF
);
    logic [ID_WIDTH+NUM_SENSORS*TS_WIDTH-1:0] in_data;
    logic                                     in_valid;
    logic                                     in_ready;
    logic [2*NUM_SENSORS*TS_WIDTH-1:0]        out_pairs;
    logic [ID_WIDTH-1:0]                      out_id;
    logic                                     out_valid;
    logic                                     out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_pairs, out_id, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_pairs, out_id, out_valid
    );
endinterface

// File: rtl/sweep_pair_tracker_slot_table.sv
// Table of half-pairs awaiting their second sweep: parallel ID lookup with gap test,
// free/oldest slot selection for stores, and per-slot aging with expiry.
module sweep_pair_tracker_slot_table #(
    parameter int NUM_SENSORS = 3,
    parameter int TS_WIDTH    = 17,
    parameter int ID_WIDTH    = 17,
    parameter int NUM_SLOTS   = 4,
    parameter int MIN_DIFF    = 7500,
    parameter int MAX_AGE     = 2**20,
    parameter int IDX_W       = $clog2(NUM_SLOTS),
    parameter int AGE_W       = $clog2(MAX_AGE + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ID_WIDTH-1:0]             i_id,
    input  logic [NUM_SENSORS*TS_WIDTH-1:0] i_ts,
    input  logic                            i_write,
    input  logic                            i_clear,
    input  logic [IDX_W-1:0]                i_clear_idx,
    output logic                            o_hit,
    output logic [IDX_W-1:0]                o_hit_idx,
    output logic [NUM_SENSORS*TS_WIDTH-1:0] o_hit_ts,
    output logic                            o_gap_ok,
    output logic                            o_evict,
    output logic                            o_any_valid
);
    localparam logic [AGE_W-1:0]    AGE_LAST = AGE_W'(MAX_AGE - 1);
    localparam logic [AGE_W-1:0]    AGE_SAT  = AGE_W'(MAX_AGE);
    localparam logic [TS_WIDTH:0]   GAP      = (TS_WIDTH + 1)'(MIN_DIFF);

    logic [NUM_SLOTS-1:0]            r_valid;
    logic [ID_WIDTH-1:0]             r_id  [NUM_SLOTS];
    logic [NUM_SENSORS*TS_WIDTH-1:0] r_ts  [NUM_SLOTS];
    logic [AGE_W-1:0]                r_age [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]   w_match;
    logic [NUM_SENSORS-1:0] w_gap;
    logic                   w_free_found;
    logic [IDX_W-1:0]       w_free_idx;
    logic [IDX_W-1:0]       w_old_idx;
    logic [AGE_W-1:0]       w_old_age;
    logic [IDX_W-1:0]       w_wr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_id[gi] == i_id);
        end
        // Widened by one bit so a stored stamp near the top of range cannot wrap past the new one.
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_gap
            assign w_gap[gi] = ({1'b0, o_hit_ts[gi*TS_WIDTH +: TS_WIDTH]} + GAP)
                             < {1'b0, i_ts[gi*TS_WIDTH +: TS_WIDTH]};
        end
    endgenerate

    always_comb begin
        o_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_old_idx    = '0;
        w_old_age    = r_age[0];
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_match[i]) o_hit_idx = IDX_W'(i);
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
        for (int i = 1; i < NUM_SLOTS; i++) begin
            if (r_age[i] > w_old_age) begin
                w_old_age = r_age[i];
                w_old_idx = IDX_W'(i);
            end
        end
    end

    assign o_hit       = |w_match;
    assign o_hit_ts    = r_ts[o_hit_idx];
    assign o_gap_ok    = &w_gap;
    assign o_evict     = !w_free_found;
    assign o_any_valid = |r_valid;
    assign w_wr_idx    = w_free_found ? w_free_idx : w_old_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_id[i]  <= '0;
                r_ts[i]  <= '0;
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (i_write && (w_wr_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_id[i]    <= i_id;
                    r_ts[i]    <= i_ts;
                    r_age[i]   <= '0;
                end else if (i_clear && (i_clear_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b0;
                    r_age[i]   <= '0;
                end else if (r_valid[i]) begin
                    if (r_age[i] == AGE_LAST) begin
                        r_valid[i] <= 1'b0;
                        r_age[i]   <= AGE_SAT;
                    end else begin
                        r_age[i] <= r_age[i] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/sweep_pair_tracker.sv
// Pairs successive sweep records of the same base-station ID into first/second sets,
// with drop accounting and an idle heartbeat; slot storage lives in the slot table.
module sweep_pair_tracker
    import sweep_pair_tracker_pkg::*;
#(
    parameter int NUM_SENSORS = NUM_SENSORS_DEF,
    parameter int TS_WIDTH    = TS_WIDTH_DEF,
    parameter int ID_WIDTH    = ID_WIDTH_DEF,
    parameter int NUM_SLOTS   = 4,
    parameter int MIN_DIFF    = 7500,
    parameter int MAX_AGE     = 2**20
) (
    input  logic                clk_72MHz,
    input  logic                reset_n,
    sweep_pair_tracker_if.slave bus,
    output logic [15:0]         drop_count,
    output logic                idle_led
);
    localparam int TSV_W  = NUM_SENSORS * TS_WIDTH;
    localparam int REC_W  = ID_WIDTH + TSV_W;
    localparam int PAIR_W = 2 * TSV_W;
    localparam int IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    state_t              r_state, w_state_next;
    logic [REC_W-1:0]    r_rec;
    logic [PAIR_W-1:0]   r_out_pairs;
    logic [ID_WIDTH-1:0] r_out_id;
    logic                r_out_valid;
    logic [15:0]         r_drop;
    logic [25:0]         r_idle_cnt;

    logic                w_accept, w_write, w_clear, w_drop;
    logic                w_hit, w_gap_ok, w_evict, w_any_valid;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [TSV_W-1:0]    w_hit_ts;
    logic [ID_WIDTH-1:0] w_rec_id;
    logic [TSV_W-1:0]    w_rec_ts;
    logic [PAIR_W-1:0]   w_pairs;

    assign w_rec_id = r_rec[ID_LSB +: ID_WIDTH];
    assign w_rec_ts = r_rec[ts_lsb(ID_WIDTH, TS_WIDTH, 0) +: TSV_W];
    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

    sweep_pair_tracker_slot_table #(
        .NUM_SENSORS (NUM_SENSORS),
        .TS_WIDTH    (TS_WIDTH),
        .ID_WIDTH    (ID_WIDTH),
        .NUM_SLOTS   (NUM_SLOTS),
        .MIN_DIFF    (MIN_DIFF),
        .MAX_AGE     (MAX_AGE),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk         (clk_72MHz),
        .rst_n       (reset_n),
        .i_id        (w_rec_id),
        .i_ts        (w_rec_ts),
        .i_write     (w_write),
        .i_clear     (w_clear),
        .i_clear_idx (w_hit_idx),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx),
        .o_hit_ts    (w_hit_ts),
        .o_gap_ok    (w_gap_ok),
        .o_evict     (w_evict),
        .o_any_valid (w_any_valid)
    );

    // Output layout interleaves per sensor, sensor 0 at the MSBs: {first0, second0, first1, ...}.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_pair
            localparam int HI = 2 * (NUM_SENSORS - gi) * TS_WIDTH - 1;
            assign w_pairs[HI -: TS_WIDTH]            = w_hit_ts[gi*TS_WIDTH +: TS_WIDTH];
            assign w_pairs[HI - TS_WIDTH -: TS_WIDTH] = r_rec[ts_lsb(ID_WIDTH, TS_WIDTH, gi) +: TS_WIDTH];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_clear      = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (w_hit && w_gap_ok) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_EMIT;
                end else if (w_hit) begin
                    w_drop       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_STORE;
                end
            end
            ST_STORE: begin
                w_write      = 1'b1;
                w_drop       = w_evict;
                w_state_next = ST_IDLE;
            end
            ST_EMIT: begin
                if (bus.out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rec       <= '0;
            r_out_pairs <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
            r_drop      <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_rec <= bus.in_data;
            // The hit slot is consumed on the same edge the pair is captured, so it cannot expire first.
            if (w_clear) begin
                r_out_pairs <= w_pairs;
                r_out_id    <= w_rec_id;
                r_out_valid <= 1'b1;
            end else if ((r_state == ST_EMIT) && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
            if ((r_state == ST_IDLE) && !w_any_valid) r_idle_cnt <= r_idle_cnt + 26'd1;
            else                                       r_idle_cnt <= '0;
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_pairs = r_out_pairs;
    assign bus.out_id    = r_out_id;
    assign bus.out_valid = r_out_valid;
    assign drop_count    = r_drop;
    assign idle_led      = r_idle_cnt[25];
endmodule

// File: tb/tb_sweep_pair_tracker.sv
// Directed plus randomized bench for sweep_pair_tracker against a slot-level reference model;
// a second instance with a short MAX_AGE covers expiry and reset during EMIT.
module tb_sweep_pair_tracker;
    localparam int NS       = 3;
    localparam int TW       = 17;
    localparam int IW       = 17;
    localparam int NSLOT    = 4;
    localparam int MIN_DIFF = 7500;
    localparam int PW       = 2 * NS * TW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [IW+NS*TW-1:0] tb_data  = '0;
    logic                tb_valid = 1'b0;
    logic                tb_ready = 1'b1;
    int                  sel      = 0;

    logic [15:0] drop0, drop1;
    logic        led0, led1;

    sweep_pair_tracker_if if0 ();
    sweep_pair_tracker_if if1 ();

    assign if0.in_data   = tb_data;
    assign if1.in_data   = tb_data;
    assign if0.in_valid  = tb_valid && (sel == 0);
    assign if1.in_valid  = tb_valid && (sel == 1);
    assign if0.out_ready = tb_ready;
    assign if1.out_ready = tb_ready;

    sweep_pair_tracker u_dut (
        .clk_72MHz  (clk),
        .reset_n    (reset_n),
        .bus        (if0),
        .drop_count (drop0),
        .idle_led   (led0)
    );

    sweep_pair_tracker #(.MAX_AGE(16)) u_age (
        .clk_72MHz  (clk),
        .reset_n    (reset_n),
        .bus        (if1),
        .drop_count (drop1),
        .idle_led   (led1)
    );

    logic          m_in_ready, m_out_valid, m_led;
    logic [PW-1:0] m_out_pairs;
    logic [IW-1:0] m_out_id;
    logic [15:0]   m_drop_count;
    assign m_in_ready   = sel ? if1.in_ready  : if0.in_ready;
    assign m_out_valid  = sel ? if1.out_valid : if0.out_valid;
    assign m_out_pairs  = sel ? if1.out_pairs : if0.out_pairs;
    assign m_out_id     = sel ? if1.out_id    : if0.out_id;
    assign m_drop_count = sel ? drop1 : drop0;
    assign m_led        = sel ? led1  : led0;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: which IDs are waiting, their first-sweep stamps and when they were stored.
    bit            mv  [NSLOT];
    logic [IW-1:0] mid [NSLOT];
    int            mts [NSLOT][NS];
    longint        mt  [NSLOT];
    int            m_drop;
    longint        m_max_age;

    int checks = 0;
    int errors = 0;
    int last_ts [6][NS];
    logic [IW-1:0] pool [6];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NSLOT; i++) begin
            mv[i] = 1'b0;
            mt[i] = 0;
        end
        m_drop = 0;
    endtask

    task automatic model_step(input logic [IW-1:0] id, input int t0, input int t1, input int t2,
                              input longint acc, output bit emit, output logic [PW-1:0] pairs);
        int  t [NS];
        int  hit;
        int  tgt;
        bit  ok;
        t[0] = t0; t[1] = t1; t[2] = t2;
        emit  = 1'b0;
        pairs = '0;
        hit   = -1;
        // A record stored on edge mt is gone once max_age edges have passed.
        for (int i = 0; i < NSLOT; i++)
            if (mv[i] && ((acc - mt[i]) >= m_max_age)) mv[i] = 1'b0;
        for (int i = 0; i < NSLOT; i++)
            if (mv[i] && (mid[i] == id) && (hit < 0)) hit = i;
        if (hit >= 0) begin
            ok = 1'b1;
            for (int s = 0; s < NS; s++)
                if (!(t[s] > mts[hit][s] + MIN_DIFF)) ok = 1'b0;
            if (ok) begin
                emit = 1'b1;
                for (int s = 0; s < NS; s++)
                    pairs = (pairs << (2 * TW)) | (PW'(mts[hit][s]) << TW) | PW'(t[s]);
                mv[hit] = 1'b0;
            end else begin
                m_drop++;
            end
        end else begin
            tgt = -1;
            for (int i = 0; i < NSLOT; i++)
                if (!mv[i] && (tgt < 0)) tgt = i;
            if (tgt < 0) begin
                tgt = 0;
                for (int i = 1; i < NSLOT; i++)
                    if (mt[i] < mt[tgt]) tgt = i;
                m_drop++;
            end
            mv[tgt]  = 1'b1;
            mid[tgt] = id;
            for (int s = 0; s < NS; s++) mts[tgt][s] = t[s];
            mt[tgt]  = acc + 2;
        end
    endtask

    task automatic send(input logic [IW-1:0] id, input int t0, input int t1, input int t2, input int hold);
        bit            emit;
        logic [PW-1:0] exp_pairs;
        longint        acc;
        int            n;
        tb_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!m_in_ready && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", m_in_ready, 1);
        tb_data  = {TW'(t2), TW'(t1), TW'(t0), id};
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        acc      = cyc;
        tb_valid = 1'b0;
        model_step(id, t0, t1, t2, acc, emit, exp_pairs);
        chk("in_ready_busy", m_in_ready, 0);
        chk("ov_lookup", m_out_valid, 0);
        @(posedge clk);
        #1;
        chk("ov_emit", m_out_valid, emit);
        if (emit) begin
            chk("out_pairs", m_out_pairs, exp_pairs);
            chk("out_id", m_out_id, id);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                chk("hold_ov", m_out_valid, 1);
                chk("hold_pairs", m_out_pairs, exp_pairs);
                chk("hold_id", m_out_id, id);
                chk("hold_in_ready", m_in_ready, 0);
            end
            tb_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("ov_after", m_out_valid, 0);
        chk("drop_count", m_drop_count, 16'(m_drop));
        $display("txn dut=%0d id=%05h ts=%0d/%0d/%0d hold=%0d emit=%0d drop=%0d",
                 sel, id, t0, t1, t2, hold, emit, m_drop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int mode;
        int t [NS];

        sel       = 0;
        m_max_age = 64'd1 << 20;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", m_in_ready, 1);
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_out_pairs", m_out_pairs, 0);
        chk("rst_out_id", m_out_id, 0);
        chk("rst_drop", m_drop_count, 0);
        chk("rst_led", m_led, 0);
        chk("rst_drop_age", drop1, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic pairing
        send(17'h1A2B3, 1000, 2000, 3000, 0);
        send(17'h1A2B3, 9000, 10000, 11000, 0);
        chk("t1_idle_led", m_led, 0);

        // Exact-gap boundary on sensor 1, all-zero ID
        send(17'h00000, 100, 200, 300, 0);
        send(17'h00000, 7601, 7700, 7801, 0);
        send(17'h00000, 7601, 7701, 7801, 0);

        // Interleaved IDs
        send(17'h0AAAA, 10, 20, 30, 0);
        send(17'h05555, 40, 50, 60, 0);
        send(17'h0AAAA, 10000, 10000, 10000, 0);
        send(17'h05555, 20000, 20000, 20000, 0);

        // Five distinct IDs into four slots, then the evicted ID again
        for (int i = 0; i < 5; i++) send(IW'(17'h00100 + i), 500, 500, 500, 0);
        send(17'h00100, 9000, 9000, 9000, 0);

        // Back-pressure held for 10 cycles
        send(17'h00103, 9000, 9000, 9000, 10);

        // Randomized records over a pool larger than the table
        pool[0] = 17'h00102; pool[1] = 17'h00103; pool[2] = 17'h00104;
        pool[3] = 17'h00100; pool[4] = 17'h1FFFF; pool[5] = 17'h00000;
        for (int i = 0; i < 6; i++)
            for (int s = 0; s < NS; s++) last_ts[i][s] = $urandom_range(0, 60000);
        for (int r = 0; r < 150; r++) begin
            p    = $urandom_range(0, 5);
            mode = $urandom_range(0, 2);
            for (int s = 0; s < NS; s++) begin
                if (mode == 0) t[s] = $urandom_range(0, 131071);
                else           t[s] = (last_ts[p][s] + $urandom_range(7495, 7520)) & 17'h1FFFF;
                last_ts[p][s] = t[s];
            end
            send(pool[p], t[0], t[1], t[2], $urandom_range(0, 3));
        end

        // Short-lifetime instance: expiry, then reset during EMIT
        sel       = 1;
        m_max_age = 16;
        model_clear();
        send(17'h00ABC, 100, 100, 100, 0);
        repeat (20) @(posedge clk);
        send(17'h00ABC, 9000, 9000, 9000, 0);
        send(17'h00ABC, 17000, 17000, 17000, 0);

        send(17'h00DEF, 100, 100, 100, 0);
        tb_ready = 1'b0;
        @(negedge clk);
        tb_data  = {TW'(9000), TW'(9000), TW'(9000), 17'h00DEF};
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_ov", m_out_valid, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_rst_ov", m_out_valid, 0);
        chk("async_rst_pairs", m_out_pairs, 0);
        chk("async_rst_in_ready", m_in_ready, 1);
        chk("async_rst_drop", m_drop_count, 0);
        $display("txn dut=1 async reset during EMIT");
        @(negedge clk);
        reset_n  = 1'b1;
        tb_ready = 1'b1;
        model_clear();
        send(17'h00DEF, 20000, 20000, 20000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
